// File: rtl/i_cache.sv
// Direct-mapped one-word-per-line I-cache: hit data 1 cycle after request, miss = 1 + mem_ctrl fetch + 1.
// Backpressure: if_stall_o holds IF off for the whole miss; a jump abandons the outstanding fetch.
module i_cache #(
    parameter int LINES  = 128,
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_pc_i,
    input  logic              is_jump,
    output logic [INST_W-1:0] if_inst_o,
    output logic              if_inst_valid_o,
    output logic              if_stall_o,
    output logic              icache_needed,
    output logic [ADDR_W-1:0] icache_addr,
    input  logic [INST_W-1:0] mem_inst_i,
    input  logic              mem_inst_valid_i
);
    localparam int INDEX_W = $clog2(LINES);
    localparam int TAG_W   = ADDR_W - INDEX_W - 2;

    typedef enum logic {IDLE, MISS} state_t;
    state_t state, state_next;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [INST_W-1:0] data_q [LINES];
    logic [ADDR_W-1:0] miss_pc;

    logic [INDEX_W-1:0] req_index, miss_index;
    logic [TAG_W-1:0]   req_tag, miss_tag;
    logic               hit;
    logic               lookup, miss_start, fill, deliver, miss_end;
    logic               unused_pc_bits;

    assign req_index      = if_pc_i[INDEX_W+1:2];
    assign req_tag        = if_pc_i[ADDR_W-1:INDEX_W+2];
    assign miss_index     = miss_pc[INDEX_W+1:2];
    assign miss_tag       = miss_pc[ADDR_W-1:INDEX_W+2];
    assign unused_pc_bits = ^{if_pc_i[1:0], miss_pc[1:0]};
    assign hit            = valid_q[req_index] && (tag_q[req_index] == req_tag);

    assign if_stall_o  = (state == MISS);
    assign icache_addr = miss_pc;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        lookup     = 1'b0;
        miss_start = 1'b0;
        fill       = 1'b0;
        deliver    = 1'b0;
        miss_end   = 1'b0;
        case (state)
            IDLE: begin
                if (if_req_i && !is_jump) begin
                    if (hit) begin
                        lookup = 1'b1;
                    end else begin
                        miss_start = 1'b1;
                        state_next = MISS;
                    end
                end
            end
            MISS: begin
                // A response arriving with a jump still belongs to miss_pc, so keep it.
                if (mem_inst_valid_i) begin
                    fill       = 1'b1;
                    deliver    = !is_jump;
                    miss_end   = 1'b1;
                    state_next = IDLE;
                end else if (is_jump) begin
                    miss_end   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_inst_o       <= '0;
            if_inst_valid_o <= 1'b0;
            icache_needed   <= 1'b0;
            miss_pc         <= '0;
            valid_q         <= '0;
        end else begin
            if_inst_valid_o <= lookup || deliver;
            if (lookup)  if_inst_o <= data_q[req_index];
            if (deliver) if_inst_o <= mem_inst_i;
            if (miss_start) begin
                miss_pc       <= {if_pc_i[ADDR_W-1:2], 2'b00};
                icache_needed <= 1'b1;
            end
            if (miss_end) icache_needed <= 1'b0;
            if (fill)     valid_q[miss_index] <= 1'b1;
        end
    end

    // Tag/data carry no reset; the valid bits alone decide whether a line is usable.
    always_ff @(posedge clk) begin
        if (fill && !rst) begin
            tag_q[miss_index]  <= miss_tag;
            data_q[miss_index] <= mem_inst_i;
        end
    end
endmodule

// File: tb/tb_i_cache.sv
// Directed bench for i_cache: inputs change 1ns after posedge, outputs checked 1ns after posedge.
module tb_i_cache;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_pc_i;
    logic        is_jump;
    logic [31:0] if_inst_o;
    logic        if_inst_valid_o;
    logic        if_stall_o;
    logic        icache_needed;
    logic [31:0] icache_addr;
    logic [31:0] mem_inst_i;
    logic        mem_inst_valid_i;

    int checks = 0;
    int passed = 0;

    i_cache dut (
        .clk              (clk),
        .rst              (rst),
        .if_req_i         (if_req_i),
        .if_pc_i          (if_pc_i),
        .is_jump          (is_jump),
        .if_inst_o        (if_inst_o),
        .if_inst_valid_o  (if_inst_valid_o),
        .if_stall_o       (if_stall_o),
        .icache_needed    (icache_needed),
        .icache_addr      (icache_addr),
        .mem_inst_i       (mem_inst_i),
        .mem_inst_valid_i (mem_inst_valid_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Request pc, expect a miss, wait a few mem_ctrl cycles, then return data.
    task automatic fill(input string tag, input logic [31:0] pc, input logic [31:0] data);
        if_req_i = 1'b1;
        if_pc_i  = pc;
        tick();
        if_req_i = 1'b0;
        chk({tag, "_needed"}, 32'(icache_needed), 32'd1);
        chk({tag, "_addr"}, icache_addr, pc);
        chk({tag, "_stall"}, 32'(if_stall_o), 32'd1);
        repeat (4) tick();
        chk({tag, "_held"}, 32'(icache_needed), 32'd1);
        mem_inst_i       = data;
        mem_inst_valid_i = 1'b1;
        tick();
        mem_inst_valid_i = 1'b0;
        chk({tag, "_valid"}, 32'(if_inst_valid_o), 32'd1);
        chk({tag, "_inst"}, if_inst_o, data);
        chk({tag, "_needed_clr"}, 32'(icache_needed), 32'd0);
    endtask

    initial begin
        rst = 1'b1; if_req_i = 1'b0; if_pc_i = '0; is_jump = 1'b0;
        mem_inst_i = '0; mem_inst_valid_i = 1'b0;
        tick(); tick();
        chk("rst_valid", 32'(if_inst_valid_o), 32'd0);
        chk("rst_needed", 32'(icache_needed), 32'd0);
        chk("rst_stall", 32'(if_stall_o), 32'd0);
        chk("rst_inst", if_inst_o, 32'd0);
        rst = 1'b0;

        // Cold miss at 0x0, then 0x4
        fill("t1_pc0", 32'h0, 32'h0000_0013);
        fill("t2_pc4", 32'h4, 32'h0040_0093);

        // Back-to-back hits
        if_req_i = 1'b1; if_pc_i = 32'h0;
        tick();
        chk("t2_hit0_valid", 32'(if_inst_valid_o), 32'd1);
        chk("t2_hit0_inst", if_inst_o, 32'h0000_0013);
        chk("t2_hit0_needed", 32'(icache_needed), 32'd0);
        if_pc_i = 32'h4;
        tick();
        chk("t2_hit4_valid", 32'(if_inst_valid_o), 32'd1);
        chk("t2_hit4_inst", if_inst_o, 32'h0040_0093);
        chk("t2_hit4_needed", 32'(icache_needed), 32'd0);
        if_req_i = 1'b0;
        tick();
        chk("t2_idle_valid", 32'(if_inst_valid_o), 32'd0);

        // Conflict at index 0: 0x200 evicts 0x0, 0x0 then misses again
        fill("t3_pc200", 32'h200, 32'hAAAA_0001);
        fill("t3_pc0_again", 32'h0, 32'h0000_0013);

        // Jump in IDLE drops the request
        if_req_i = 1'b1; if_pc_i = 32'h0; is_jump = 1'b1;
        tick();
        if_req_i = 1'b0; is_jump = 1'b0;
        chk("jmp_idle_valid", 32'(if_inst_valid_o), 32'd0);
        chk("jmp_idle_needed", 32'(icache_needed), 32'd0);

        // Abort miss at 0x8, late response ignored
        if_req_i = 1'b1; if_pc_i = 32'h8;
        tick();
        if_req_i = 1'b0;
        chk("t4_needed", 32'(icache_needed), 32'd1);
        chk("t4_addr", icache_addr, 32'h8);
        tick();
        is_jump = 1'b1;
        tick();
        is_jump = 1'b0;
        chk("t4_abort_needed", 32'(icache_needed), 32'd0);
        chk("t4_abort_stall", 32'(if_stall_o), 32'd0);
        chk("t4_abort_valid", 32'(if_inst_valid_o), 32'd0);
        mem_inst_i = 32'h5555_5555; mem_inst_valid_i = 1'b1;
        tick();
        mem_inst_valid_i = 1'b0;
        chk("t4_late_valid", 32'(if_inst_valid_o), 32'd0);
        if_req_i = 1'b1; if_pc_i = 32'h8;
        tick();
        if_req_i = 1'b0;
        chk("t4_line2_invalid", 32'(icache_needed), 32'd1);
        is_jump = 1'b1;
        tick();
        is_jump = 1'b0;
        chk("t4_abort2_needed", 32'(icache_needed), 32'd0);

        // Jump coincident with response: line filled, no delivery
        if_req_i = 1'b1; if_pc_i = 32'hC;
        tick();
        if_req_i = 1'b0;
        chk("t5_needed", 32'(icache_needed), 32'd1);
        tick();
        is_jump = 1'b1; mem_inst_i = 32'hDEAD_BEEF; mem_inst_valid_i = 1'b1;
        tick();
        is_jump = 1'b0; mem_inst_valid_i = 1'b0;
        chk("t5_no_valid", 32'(if_inst_valid_o), 32'd0);
        chk("t5_needed_clr", 32'(icache_needed), 32'd0);
        chk("t5_stall_clr", 32'(if_stall_o), 32'd0);
        if_req_i = 1'b1; if_pc_i = 32'hC;
        tick();
        if_req_i = 1'b0;
        chk("t5_hit_valid", 32'(if_inst_valid_o), 32'd1);
        chk("t5_hit_inst", if_inst_o, 32'hDEAD_BEEF);
        chk("t5_hit_needed", 32'(icache_needed), 32'd0);

        // Reset mid-miss clears outputs and every valid bit
        if_req_i = 1'b1; if_pc_i = 32'h10;
        tick();
        if_req_i = 1'b0;
        chk("t6_needed", 32'(icache_needed), 32'd1);
        chk("t6_addr", icache_addr, 32'h10);
        rst = 1'b1; mem_inst_i = 32'h1111_1111; mem_inst_valid_i = 1'b1;
        tick();
        rst = 1'b0; mem_inst_valid_i = 1'b0;
        chk("t6_rst_needed", 32'(icache_needed), 32'd0);
        chk("t6_rst_addr", icache_addr, 32'd0);
        chk("t6_rst_valid", 32'(if_inst_valid_o), 32'd0);
        chk("t6_rst_inst", if_inst_o, 32'd0);
        chk("t6_rst_stall", 32'(if_stall_o), 32'd0);
        fill("t6_pc0_cold", 32'h0, 32'h0000_0013);
        fill("t6_pc10_nofill", 32'h10, 32'h2222_2222);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
